// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, buffer depth and target port codes.
package noc_pkg;

  localparam int unsigned FLIT_W     = 23;
  localparam int unsigned PAYLOAD_HI = 22;
  localparam int unsigned PAYLOAD_LO = 7;
  localparam int unsigned ADDR_HI    = 6;
  localparam int unsigned ADDR_LO    = 3;
  localparam int unsigned TGT_HI     = 2;
  localparam int unsigned TGT_LO     = 0;
  localparam int unsigned BUF_DEPTH  = 9;

  typedef enum logic [2:0] {
    TgtLocal = 3'd0,
    TgtNorth = 3'd1,
    TgtEast  = 3'd2,
    TgtSouth = 3'd3,
    TgtWest  = 3'd4
  } tgt_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NUM_IN = 5,
  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              enable,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              any_gnt
);

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int unsigned off = 0; off < NUM_IN; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (enable && !any_gnt && req[IDX_W'(idx)]) begin
        gnt[IDX_W'(idx)] = 1'b1;
        gnt_idx          = IDX_W'(idx);
        any_gnt          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port switch allocator with credit-based flow control.
// Define ARB_STATS_EN to add saturating sent/stall statistics counters.
module output_port_arbiter #(
  parameter int unsigned NUM_IN  = 5,
  parameter int unsigned FLIT_W  = noc_pkg::FLIT_W,
  parameter logic [2:0]  PORT_ID = 3'd0,
  parameter int unsigned CREDITS = noc_pkg::BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*FLIT_W-1:0] in_flit,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_pop,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_valid,
  input  logic                     credit_ret,
  output logic [3:0]               credit_cnt,
  output logic                     credit_err
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]              sent_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  import noc_pkg::*;

  localparam int unsigned IDX_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [3:0]  CRED_MAX = 4'(CREDITS);

  logic [FLIT_W-1:0] flit [NUM_IN];
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic              arb_en;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [FLIT_W-1:0] out_flit_q;
  logic              out_valid_q;
  logic [3:0]        credit_q, credit_d;
  logic              err_q, err_d;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_req
    assign flit[i] = in_flit[i*FLIT_W +: FLIT_W];
    assign req[i]  = in_valid[i] && (flit[i][TGT_HI:TGT_LO] == PORT_ID);
  end

  // Gating with rst keeps in_pop quiet while reset is held.
  assign arb_en = rst && (credit_q != '0);

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .enable  (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  always_comb begin
    rr_ptr_d = (32'(gnt_idx) == NUM_IN - 1) ? '0 : gnt_idx + 1'b1;
    credit_d = credit_q;
    err_d    = err_q;
    case ({any_gnt, credit_ret})
      2'b10: credit_d = credit_q - 4'd1;
      2'b01: begin
        if (credit_q == CRED_MAX) err_d = 1'b1;
        else credit_d = credit_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
      credit_q    <= CRED_MAX;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= any_gnt;
      if (any_gnt) begin
        out_flit_q <= flit[gnt_idx];
        rr_ptr_q   <= rr_ptr_d;
      end
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign in_pop     = gnt;
  assign out_flit   = out_flit_q;
  assign out_valid  = out_valid_q;
  assign credit_cnt = credit_q;
  assign credit_err = err_q;

`ifdef ARB_STATS_EN
  logic [15:0] sent_q, stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      if (any_gnt && sent_q != 16'hFFFF) sent_q <= sent_q + 16'd1;
      if ((|req) && credit_q == '0 && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign sent_cnt  = sent_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Randomised self-checking bench for output_port_arbiter against a behavioural model.
module tb_output_port_arbiter;

  localparam int N   = 5;
  localparam int W   = 23;
  localparam int PID = 2;
  localparam int CR  = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N*W-1:0]   in_flit;
  logic [N-1:0]     in_valid = '0;
  logic [N-1:0]     in_pop;
  logic [W-1:0]     out_flit;
  logic             out_valid;
  logic             credit_ret = 1'b0;
  logic [3:0]       credit_cnt;
  logic             credit_err;
`ifdef ARB_STATS_EN
  logic [15:0]      sent_cnt, stall_cnt;
`endif

  logic [W-1:0] f [N];
  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int           m_ptr, m_credit, m_sent, m_stall;
  logic         m_err, m_out_valid;
  logic [W-1:0] m_out_flit;

  output_port_arbiter #(
    .NUM_IN  (N),
    .FLIT_W  (W),
    .PORT_ID (3'(PID)),
    .CREDITS (CR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_pop     (in_pop),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .credit_ret (credit_ret),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
`ifdef ARB_STATS_EN
    ,
    .sent_cnt   (sent_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    in_flit = '0;
    for (int i = 0; i < N; i++) in_flit[i*W +: W] = f[i];
  end

  function automatic logic [W-1:0] mk(int tgt);
    return {16'($urandom), 4'($urandom), 3'(tgt)};
  endfunction

  function automatic bit requesting(int i);
    return in_valid[i] && (f[i][2:0] == 3'(PID));
  endfunction

  // Winner = requester at the smallest circular distance from the pointer.
  function automatic int exp_grant();
    int best, bestd, d;
    best  = -1;
    bestd = N;
    if (!rst || m_credit == 0) return -1;
    for (int i = 0; i < N; i++) begin
      d = (i - m_ptr + N) % N;
      if (requesting(i) && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_pop();
    int g;
    logic [N-1:0] p;
    g = exp_grant();
    p = '0;
    if (g >= 0) p[g] = 1'b1;
    return p;
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_credit = CR; m_err = 1'b0; m_out_valid = 1'b0; m_out_flit = '0;
    m_sent = 0; m_stall = 0;
  endfunction

  // Clock edge, then apply the spec rules to the model using the pre-edge inputs.
  task automatic advance();
    int g;
    bit anyreq;
    @(posedge clk);
    #1;
    g = exp_grant();
    anyreq = 1'b0;
    for (int i = 0; i < N; i++) if (requesting(i)) anyreq = 1'b1;
    if (anyreq && m_credit == 0 && m_stall < 65535) m_stall++;
    if (g >= 0) begin
      m_out_valid = 1'b1;
      m_out_flit  = f[g];
      m_ptr       = (g + 1) % N;
      if (m_sent < 65535) m_sent++;
      if (!credit_ret) m_credit--;
    end else begin
      m_out_valid = 1'b0;
      if (credit_ret) begin
        if (m_credit == CR) m_err = 1'b1;
        else m_credit++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #4;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_flit !== '0) begin bad++; $display("FAIL reset_flit got=%h want=0", out_flit); end
    total++; if (credit_cnt !== 4'(CR)) begin bad++; $display("FAIL reset_credit got=%0d want=%0d", credit_cnt, CR); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", credit_err); end
    total++; if (in_pop !== '0) begin bad++; $display("FAIL reset_pop got=%b want=0", in_pop); end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_single();
    f[0] = mk(PID);
    in_valid = 5'b00001;
    #4;
    total++; if (in_pop !== 5'b00001) begin bad++; $display("FAIL single_pop got=%b want=00001", in_pop); end
    advance();
    in_valid = '0;
    #4;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
    total++; if (out_flit !== f[0]) begin bad++; $display("FAIL single_flit got=%h want=%h", out_flit, f[0]); end
    total++; if (credit_cnt !== 4'd8) begin bad++; $display("FAIL single_credit got=%0d want=8", credit_cnt); end
    credit_ret = 1'b1;
    advance();
    credit_ret = 1'b0;
  endtask

  task automatic test_round_robin();
    int start;
    start = m_ptr;
    in_valid = '1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) f[i] = mk(PID);
      credit_ret = (m_credit < 5);
      #4;
      total++;
      if (in_pop !== exp_pop() || in_pop !== 5'(1 << ((start + c) % N))) begin
        bad++; $display("FAIL rr_order cyc=%0d got=%b want=%b", c, in_pop, exp_pop());
      end
      advance();
      total++; if (out_flit !== m_out_flit) begin bad++; $display("FAIL rr_flit got=%h want=%h", out_flit, m_out_flit); end
    end
    in_valid = '0;
    credit_ret = 1'b0;
  endtask

  task automatic test_target_filter();
    in_valid = '1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) f[i] = (i == 3) ? mk(PID) : mk((PID + 1 + $urandom_range(0, 5)) % 8);
      credit_ret = (m_credit < 5);
      #4;
      total++; if (in_pop !== 5'b01000) begin bad++; $display("FAIL filter_pop got=%b want=01000", in_pop); end
      advance();
    end
    in_valid = '0;
    credit_ret = 1'b0;
  endtask

  task automatic test_credit_exhaust();
    while (m_credit < CR) begin credit_ret = 1'b1; advance(); end
    credit_ret = 1'b0;
    in_valid = '1;
    for (int i = 0; i < N; i++) f[i] = mk(PID);
    for (int c = 0; c < 11; c++) begin
      #4;
      total++; if (in_pop !== exp_pop()) begin bad++; $display("FAIL exh_pop cyc=%0d got=%b want=%b", c, in_pop, exp_pop()); end
      advance();
    end
    #4;
    total++; if (credit_cnt !== 4'd0) begin bad++; $display("FAIL exh_credit got=%0d want=0", credit_cnt); end
    total++; if (in_pop !== '0) begin bad++; $display("FAIL exh_stall got=%b want=0", in_pop); end
    credit_ret = 1'b1;
    #1;
    total++; if (in_pop !== '0) begin bad++; $display("FAIL exh_ret_same got=%b want=0", in_pop); end
    advance();
    credit_ret = 1'b0;
    #4;
    total++; if (credit_cnt !== 4'd1) begin bad++; $display("FAIL exh_one got=%0d want=1", credit_cnt); end
    total++; if (in_pop === '0 || in_pop !== exp_pop()) begin bad++; $display("FAIL exh_resume got=%b want=%b", in_pop, exp_pop()); end
`ifdef ARB_STATS_EN
    total++; if (stall_cnt !== 16'(m_stall)) begin bad++; $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, m_stall); end
`endif
    advance();
    in_valid = '0;
  endtask

  task automatic test_simultaneous();
    while (m_credit != 4) begin
      in_valid   = (m_credit > 4) ? 5'b11111 : 5'b00000;
      credit_ret = (m_credit < 4);
      advance();
    end
    in_valid = '1;
    credit_ret = 1'b1;
    #4;
    total++; if (in_pop === '0) begin bad++; $display("FAIL simul_pop got=%b want=nonzero", in_pop); end
    advance();
    in_valid = '0;
    #4;
    total++; if (credit_cnt !== 4'd4) begin bad++; $display("FAIL simul_credit got=%0d want=4", credit_cnt); end
    while (m_credit < CR) advance();
    #4;
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL pre_ovf_err got=%b want=0", credit_err); end
    advance();
    credit_ret = 1'b0;
    #4;
    total++; if (credit_cnt !== 4'(CR)) begin bad++; $display("FAIL ovf_credit got=%0d want=%0d", credit_cnt, CR); end
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b want=1", credit_err); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid = 5'($urandom);
      for (int i = 0; i < N; i++) f[i] = mk($urandom_range(0, 3));
      credit_ret = ($urandom_range(0, 2) == 0);
      #4;
      total++; if (in_pop !== exp_pop()) begin bad++; $display("FAIL rand_pop cyc=%0d got=%b want=%b", c, in_pop, exp_pop()); end
      total++;
      if (out_valid !== m_out_valid || out_flit !== m_out_flit || credit_cnt !== 4'(m_credit) ||
          credit_err !== m_err) begin
        bad++;
        $display("FAIL rand_state cyc=%0d got=%b/%h/%0d/%b want=%b/%h/%0d/%b", c, out_valid, out_flit,
                 credit_cnt, credit_err, m_out_valid, m_out_flit, m_credit, m_err);
      end
      advance();
    end
`ifdef ARB_STATS_EN
    #4;
    total++; if (sent_cnt !== 16'(m_sent)) begin bad++; $display("FAIL sent_cnt got=%0d want=%0d", sent_cnt, m_sent); end
    total++; if (stall_cnt !== 16'(m_stall)) begin bad++; $display("FAIL rand_stall got=%0d want=%0d", stall_cnt, m_stall); end
`endif
    credit_ret = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = '1;
    for (int i = 0; i < N; i++) f[i] = mk(PID);
    advance();
    advance();
    #2 rst = 1'b0;
    #1;
    model_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
    total++; if (in_pop !== '0) begin bad++; $display("FAIL mid_pop got=%b want=0", in_pop); end
    total++; if (credit_cnt !== 4'(CR)) begin bad++; $display("FAIL mid_credit got=%0d want=%0d", credit_cnt, CR); end
    @(posedge clk);
    #1 rst = 1'b1;
    #4;
    total++; if (in_pop !== 5'b00001) begin bad++; $display("FAIL mid_ptr got=%b want=00001", in_pop); end
    advance();
    #4;
    total++; if (out_flit !== f[0] || out_valid !== 1'b1) begin bad++; $display("FAIL mid_flit got=%h want=%h", out_flit, f[0]); end
    in_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) f[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_target_filter();
    test_credit_exhaust();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
